// File: rtl/keypad_matrix_scanner_pkg.sv
// ----------------------------------------------------------------------------
// pong_kp_pkg
// Shared constants for the keypad scanner: the row/column to key-code map,
// the key codes used by the Pong controls, and the row priority encoder
// that picks which key press gets reported when several rise together.
// ----------------------------------------------------------------------------
package pong_kp_pkg;

   // KEY_LUT[row][col] gives the hex code printed on the key.
   localparam logic [0:3][0:3][3:0] KEY_LUT = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'h0, 4'hF, 4'hE, 4'hD}
   };

   localparam logic [3:0] KEY_UP1   = 4'hA;
   localparam logic [3:0] KEY_DOWN1 = 4'h0;
   localparam logic [3:0] KEY_UP2   = 4'h8;
   localparam logic [3:0] KEY_DOWN2 = 4'h7;
   localparam logic [3:0] KEY_START = 4'hF;

   typedef struct packed {
      logic       hit;
      logic [1:0] row;
   } row_sel_t;

   // Lowest set row index wins.
   function automatic row_sel_t row_priority(input logic [3:0] i_rows);
      row_sel_t v;
      v.hit = |i_rows;
      v.row = 2'd0;
      if (i_rows[0])      v.row = 2'd0;
      else if (i_rows[1]) v.row = 2'd1;
      else if (i_rows[2]) v.row = 2'd2;
      else if (i_rows[3]) v.row = 2'd3;
      return v;
   endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// ----------------------------------------------------------------------------
// keypad_matrix_scanner_if
// Bundles the keypad pins and the decoded key outputs.
//   master : the scanner (drives columns and all key outputs, reads rows)
//   slave  : the keypad / game side (drives rows, reads everything else)
// Signals:
//   kp_row      row sense, active-low
//   kp_col      column drive, one-cold, active-low
//   key_held    debounced state, bit n = key with hex code n
//   key_valid   one-cycle press event; key_code qualifies it
//   key_code    code of the last reported press
//   up1/down1/up2/down2  paddle levels
//   start_pulse one-cycle pulse on a press of F
// key_valid is a fire-and-forget pulse: there is no ready, the consumer
// must take key_code in the cycle key_valid is high. key_code then holds.
// ----------------------------------------------------------------------------
interface keypad_matrix_scanner_if;
   logic [3:0]  kp_row;
   logic [3:0]  kp_col;
   logic [15:0] key_held;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        up1;
   logic        down1;
   logic        up2;
   logic        down2;
   logic        start_pulse;

   modport master (
      input  kp_row,
      output kp_col, key_held, key_valid, key_code,
      output up1, down1, up2, down2, start_pulse
   );

   modport slave (
      output kp_row,
      input  kp_col, key_held, key_valid, key_code,
      input  up1, down1, up2, down2, start_pulse
   );
endinterface

// File: rtl/keypad_matrix_scanner_debounce.sv
// ----------------------------------------------------------------------------
// kp_debounce
// Debounces one key. Each enabled sample that differs from the stable state
// advances a counter; an agreeing sample clears it. After DEBOUNCE_SCANS
// consecutive differing samples the stable state flips.
// Ports:
//   clk, rst      clock, async active-low reset
//   i_sample      1 = key reads pressed
//   i_sample_en   sample strobe (this key's column is being evaluated)
//   o_stable      debounced state (registered)
//   o_rise        high in the cycle whose edge flips o_stable 0->1
// ----------------------------------------------------------------------------
module kp_debounce #(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_sample,
   input  logic i_sample_en,
   output logic o_stable,
   output logic o_rise
);

   if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 7) begin : g_scans_check
      $error("DEBOUNCE_SCANS must be within 1..7");
   end

   localparam logic [2:0] CNT_LAST = 3'(DEBOUNCE_SCANS - 1);

   logic       r_stable;
   logic [2:0] r_cnt;
   logic       w_differ;
   logic       w_flip;

   assign w_differ = (i_sample != r_stable);
   // The sample that would make the count reach DEBOUNCE_SCANS flips the state.
   assign w_flip   = i_sample_en && w_differ && (r_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stable <= 1'b0;
         r_cnt    <= 3'd0;
      end else if (i_sample_en) begin
         if (!w_differ) begin
            r_cnt <= 3'd0;
         end else if (w_flip) begin
            r_stable <= ~r_stable;
            r_cnt    <= 3'd0;
         end else begin
            r_cnt <= r_cnt + 3'd1;
         end
      end
   end

   assign o_stable = r_stable;
   assign o_rise   = w_flip && !r_stable;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// ----------------------------------------------------------------------------
// keypad_matrix_scanner
// Scans a 4x4 keypad one column at a time, debounces all 16 keys and
// reports presses as one-cycle events plus held levels for the Pong controls.
// Ports:
//   clk   system clock
//   rst   async, active-low reset
//   kp    keypad_matrix_scanner_if.master (rows in; columns and key outputs)
// Parameters:
//   CLK_HZ, SCAN_HZ  column advance rate is CLK_HZ/SCAN_HZ clocks per tick
//   DEBOUNCE_SCANS   consecutive equal samples needed to change a key (1..7)
// ----------------------------------------------------------------------------
module keypad_matrix_scanner
   import pong_kp_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int SCAN_HZ        = 1_000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   keypad_matrix_scanner_if.master kp
);

   localparam int TICK_DIV = CLK_HZ / SCAN_HZ;

   // Rows need two clocks through the synchronizer after a column change,
   // so fewer than 4 clocks per tick leaves no settling margin.
   if (TICK_DIV < 4) begin : g_div_check
      $error("TICK_DIV = CLK_HZ/SCAN_HZ must be at least 4");
   end

   localparam int              TW        = $clog2(TICK_DIV);
   localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);

   logic [3:0]    r_row_s1;
   logic [3:0]    r_row_s2;
   logic [TW-1:0] r_tick_cnt;
   logic [1:0]    r_col_idx;
   logic [3:0]    r_kp_col;
   logic          r_key_valid;
   logic [3:0]    r_key_code;
   logic          r_start_pulse;

   logic          w_tick;
   logic [1:0]    w_next_col;
   logic [15:0]   w_stable_rc;
   logic [15:0]   w_rise_rc;
   logic [3:0]    w_rise_row;
   logic [15:0]   w_key_held;
   row_sel_t      w_sel;
   logic [3:0]    w_evt_code;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_row_s1 <= 4'b1111;
         r_row_s2 <= 4'b1111;
      end else begin
         r_row_s1 <= kp.kp_row;
         r_row_s2 <= r_row_s1;
      end
   end

   assign w_tick     = (r_tick_cnt == TICK_LAST);
   assign w_next_col = r_col_idx + 2'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tick_cnt <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
      end
   end

   // The column is evaluated and advanced on the same tick edge, so the new
   // column has the whole next tick period to settle through the synchronizer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_col_idx <= 2'd0;
         r_kp_col  <= 4'b1110;
      end else if (w_tick) begin
         r_col_idx <= w_next_col;
         r_kp_col  <= ~(4'b0001 << w_next_col);
      end
   end

   // One debouncer per matrix position; index r*4+c.
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         kp_debounce #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
         ) u_db (
            .clk        (clk),
            .rst        (rst),
            .i_sample   (~r_row_s2[r]),
            .i_sample_en(w_tick && (r_col_idx == 2'(c))),
            .o_stable   (w_stable_rc[r*4+c]),
            .o_rise     (w_rise_rc[r*4+c])
         );
      end
      // Only the evaluated column can rise, so OR-ing a row is enough.
      assign w_rise_row[r] = |w_rise_rc[r*4 +: 4];
   end

   // Matrix position to key-code bit order.
   always_comb begin
      w_key_held = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            w_key_held[KEY_LUT[r][c]] = w_stable_rc[r*4+c];
         end
      end
   end

   assign w_sel      = row_priority(w_rise_row);
   assign w_evt_code = KEY_LUT[w_sel.row][r_col_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_key_valid   <= 1'b0;
         r_key_code    <= 4'h0;
         r_start_pulse <= 1'b0;
      end else begin
         r_key_valid   <= w_sel.hit;
         r_start_pulse <= w_sel.hit && (w_evt_code == KEY_START);
         if (w_sel.hit) begin
            r_key_code <= w_evt_code;
         end
      end
   end

   assign kp.kp_col      = r_kp_col;
   assign kp.key_held    = w_key_held;
   assign kp.key_valid   = r_key_valid;
   assign kp.key_code    = r_key_code;
   assign kp.start_pulse = r_start_pulse;
   assign kp.up1         = w_key_held[KEY_UP1];
   assign kp.down1       = w_key_held[KEY_DOWN1];
   assign kp.up2         = w_key_held[KEY_UP2];
   assign kp.down2       = w_key_held[KEY_DOWN2];

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// ----------------------------------------------------------------------------
// tb_keypad_matrix_scanner
// Drives a keypad model (a pressed key pulls its row low while its column is
// driven) and compares every cycle against a key-level reference model.
// TICK_DIV = 4, DEBOUNCE_SCANS = 4. Key changes are applied only right after
// a tick edge, so each tick samples the key set that is current at that tick.
// ----------------------------------------------------------------------------
module tb_keypad_matrix_scanner;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   keypad_matrix_scanner_if u_if ();

   keypad_matrix_scanner #(
      .CLK_HZ        (1000),
      .SCAN_HZ       (250),
      .DEBOUNCE_SCANS(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .kp (u_if)
   );

   int lut [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

   logic [15:0] pressed = '0;

   // Physical keypad: no diodes needed since only one column is ever low.
   always_comb begin
      u_if.kp_row = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[lut[r][c]] && !u_if.kp_col[c]) u_if.kp_row[r] = 1'b0;
         end
      end
   end

   // Reference model state.
   int          n;
   logic [15:0] e_held;
   int          e_cnt [16];
   logic        e_valid;
   logic        e_start;
   logic [3:0]  e_code;

   int n_cmp   = 0;
   int n_err   = 0;
   int n_valid = 0;
   int n_start = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      n       = 0;
      e_held  = '0;
      e_valid = 1'b0;
      e_start = 1'b0;
      e_code  = 4'h0;
      for (int k = 0; k < 16; k++) e_cnt[k] = 0;
   endtask

   // One clock: advance the model at the edge, compare at the falling edge.
   task automatic step();
      int         col;
      int         k;
      logic       found;
      logic [3:0] exp_col;
      @(posedge clk);
      n++;
      e_valid = 1'b0;
      e_start = 1'b0;
      if (n % 4 == 0) begin
         col   = ((n / 4) - 1) % 4;
         found = 1'b0;
         for (int r = 0; r < 4; r++) begin
            k = lut[r][col];
            if (pressed[k] == e_held[k]) begin
               e_cnt[k] = 0;
            end else begin
               e_cnt[k]++;
               if (e_cnt[k] == 4) begin
                  e_cnt[k]  = 0;
                  e_held[k] = ~e_held[k];
                  if (e_held[k] && !found) begin
                     found  = 1'b1;
                     e_code = 4'(k);
                  end
               end
            end
         end
         e_valid = found;
         e_start = found && (e_code == 4'hF);
      end
      @(negedge clk);
      exp_col = ~(4'b0001 << ((n / 4) % 4));
      chk("kp_col",      16'(u_if.kp_col),      16'(exp_col));
      chk("key_held",    u_if.key_held,         e_held);
      chk("key_valid",   16'(u_if.key_valid),   16'(e_valid));
      chk("key_code",    16'(u_if.key_code),    16'(e_code));
      chk("start_pulse", 16'(u_if.start_pulse), 16'(e_start));
      chk("up1",         16'(u_if.up1),         16'(e_held[10]));
      chk("down1",       16'(u_if.down1),       16'(e_held[0]));
      chk("up2",         16'(u_if.up2),         16'(e_held[8]));
      chk("down2",       16'(u_if.down2),       16'(e_held[7]));
      if (u_if.key_valid)   n_valid++;
      if (u_if.start_pulse) n_start++;
   endtask

   task automatic run_ticks(input int t);
      repeat (t * 4) step();
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_kp_col"},    16'(u_if.kp_col),      16'h000E);
      chk({tag, "_key_held"},  u_if.key_held,         16'h0000);
      chk({tag, "_key_valid"}, 16'(u_if.key_valid),   16'h0000);
      chk({tag, "_key_code"},  16'(u_if.key_code),    16'h0000);
      chk({tag, "_start"},     16'(u_if.start_pulse), 16'h0000);
   endtask

   logic [3:0] col_seq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

   initial begin
      int k1;
      int k2;

      // 1: reset, then idle column rotation
      model_reset();
      #12;
      chk_reset_values("reset");
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         run_ticks(1);
         chk("col_seq", 16'(u_if.kp_col), 16'(col_seq[i]));
      end

      // 2: key A press and release
      n_valid = 0;
      n_start = 0;
      pressed = 16'h1 << 10;
      run_ticks(16);
      chk("A_up1",    16'(u_if.up1),         16'h1);
      chk("A_held",   16'(u_if.key_held[10]), 16'h1);
      chk("A_events", 16'(n_valid),          16'd1);
      chk("A_starts", 16'(n_start),          16'd0);
      chk("A_code",   16'(u_if.key_code),    16'hA);
      pressed = '0;
      run_ticks(16);
      chk("A_rel_up1",    16'(u_if.up1), 16'h0);
      chk("A_rel_events", 16'(n_valid),  16'd1);

      // 3: key 7 bounces for 3 samples, twice, separated by one open sample
      n_valid = 0;
      pressed = 16'h1 << 7;
      run_ticks(12);
      pressed = '0;
      run_ticks(4);
      pressed = 16'h1 << 7;
      run_ticks(12);
      pressed = '0;
      run_ticks(4);
      chk("bounce_down2",  16'(u_if.down2), 16'h0);
      chk("bounce_events", 16'(n_valid),    16'd0);

      // 4: keys 1 and 7 together in column 0
      n_valid = 0;
      pressed = (16'h1 << 1) | (16'h1 << 7);
      run_ticks(16);
      chk("dual_events", 16'(n_valid),        16'd1);
      chk("dual_code",   16'(u_if.key_code),  16'h1);
      chk("dual_held1",  16'(u_if.key_held[1]), 16'h1);
      chk("dual_held7",  16'(u_if.key_held[7]), 16'h1);
      chk("dual_down2",  16'(u_if.down2),     16'h1);
      pressed = '0;
      run_ticks(16);

      // 5: F held for 100 ticks
      n_valid = 0;
      n_start = 0;
      pressed = 16'h1 << 15;
      run_ticks(100);
      chk("F_starts", 16'(n_start),       16'd1);
      chk("F_events", 16'(n_valid),       16'd1);
      chk("F_code",   16'(u_if.key_code), 16'hF);
      pressed = '0;
      run_ticks(16);

      // 6: reset while key 8 is two samples into debounce
      pressed = 16'h1 << 8;
      run_ticks(8);
      rst = 1'b0;
      #1;
      chk_reset_values("midrst");
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      n_valid = 0;
      run_ticks(12);
      chk("rst_up2_early", 16'(u_if.up2), 16'h0);
      run_ticks(4);
      chk("rst_up2_late",  16'(u_if.up2), 16'h1);
      chk("rst_events",    16'(n_valid),  16'd1);
      pressed = '0;
      run_ticks(16);

      // 7: random presses of one or two keys with random durations
      for (int it = 0; it < 30; it++) begin
         k1 = $urandom_range(0, 15);
         k2 = $urandom_range(0, 15);
         pressed = 16'h1 << k1;
         if ($urandom_range(0, 1) == 1) pressed = pressed | (16'h1 << k2);
         run_ticks($urandom_range(1, 24));
         pressed = '0;
         run_ticks($urandom_range(0, 20));
      end
      run_ticks(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
